// File: rtl/bitperm_ungrp_seq.sv
// Iterative bit-scatter (inverse of group/compress): one bit position per clock.
// Pass one fills mask=1 slots, pass two fills mask=0 slots, from one shared read pointer.
module bitperm_ungrp_seq #(
    parameter int WIDTH = 32,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_mask,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SCAN_ONE  = 2'd1,
        SCAN_ZERO = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             last;
    logic             src_bit;

    assign last    = (idx_q == IDX_W'(WIDTH - 1));
    assign src_bit = data_q[ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            ptr_q    <= '0;
            data_q   <= '0;
            mask_q   <= '0;
            shadow_q <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            data_q   <= data_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        data_d   = data_q;
        mask_d   = mask_q;
        shadow_d = shadow_q;
        result_d = result_q;
        zero_d   = zero_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    data_d   = in_data;
                    mask_d   = in_mask;
                    shadow_d = '0;
                    idx_d    = '0;
                    ptr_d    = '0;
                    state_d  = SCAN_ONE;
                end
            end
            SCAN_ONE: begin
                if (mask_q[idx_q]) begin
                    shadow_d[idx_q] = src_bit;
                    ptr_d           = ptr_q + IDX_W'(1);
                end
                idx_d = idx_q + IDX_W'(1);
                if (last) begin
                    idx_d   = '0;
                    state_d = SCAN_ZERO;
                end
            end
            SCAN_ZERO: begin
                if (!mask_q[idx_q]) begin
                    shadow_d[idx_q] = src_bit;
                    ptr_d           = ptr_q + IDX_W'(1);
                end
                idx_d = idx_q + IDX_W'(1);
                // Final position: publish the completed shadow, including this bit.
                if (last) begin
                    idx_d    = '0;
                    result_d = shadow_d;
                    zero_d   = (shadow_d == '0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign zero_flag = zero_q;

endmodule
